// File: rtl/assoc_branch_target_buffer.sv
// Two-way set-associative branch target buffer.
// Combinational lookup on fetch_pc; single resolved-branch update port from execute.
// Each way holds valid, tag, target and a 2-bit saturating direction counter;
// each set holds one LRU bit naming the way to replace next.
module assoc_branch_target_buffer #(
  parameter int unsigned S_INDEX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        hit,
  output logic [31:0] target,
  output logic        predict_taken,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        invalidate_all
);

  localparam int unsigned SETS  = 2 ** S_INDEX;
  localparam int unsigned TAG_W = 30 - S_INDEX;

  logic [1:0]       valid_q [SETS];      // bit w = way w
  logic [SETS-1:0]  lru_q;
  logic [1:0]       ctr_q   [SETS][2];
  logic [TAG_W-1:0] tag_q   [SETS][2];
  logic [31:0]      tgt_q   [SETS][2];

  logic [S_INDEX-1:0] f_idx, u_idx;
  logic [TAG_W-1:0]   f_tag, u_tag;
  logic [1:0]         f_match, u_match;
  logic               u_hit, u_way, victim, wr_way;
  logic [1:0]         u_ctr;
  logic               unused_pc_bits;

  assign f_idx = fetch_pc[S_INDEX+1:2];
  assign f_tag = fetch_pc[31:S_INDEX+2];
  assign u_idx = update_pc[S_INDEX+1:2];
  assign u_tag = update_pc[31:S_INDEX+2];
  assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

  // Lookup: tag compare on both ways of the fetch set, outputs zero on miss
  always_comb begin
    f_match[0]    = valid_q[f_idx][0] && (tag_q[f_idx][0] == f_tag);
    f_match[1]    = valid_q[f_idx][1] && (tag_q[f_idx][1] == f_tag);
    hit           = |f_match;
    target        = '0;
    predict_taken = 1'b0;
    if (f_match[0]) begin
      target        = tgt_q[f_idx][0];
      predict_taken = ctr_q[f_idx][0][1];
    end else if (f_match[1]) begin
      target        = tgt_q[f_idx][1];
      predict_taken = ctr_q[f_idx][1][1];
    end
  end

  // Update decode: matching way on hit, otherwise first invalid way or the LRU way
  always_comb begin
    u_match[0] = valid_q[u_idx][0] && (tag_q[u_idx][0] == u_tag);
    u_match[1] = valid_q[u_idx][1] && (tag_q[u_idx][1] == u_tag);
    u_hit      = |u_match;
    u_way      = u_match[1];
    u_ctr      = ctr_q[u_idx][u_way];
    if (!valid_q[u_idx][0])      victim = 1'b0;
    else if (!valid_q[u_idx][1]) victim = 1'b1;
    else                         victim = lru_q[u_idx];
    wr_way = u_hit ? u_way : victim;
  end

  // Control state: valid, LRU and counters; invalidate_all drops a coincident update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lru_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s]  <= '0;
        ctr_q[s][0] <= '0;
        ctr_q[s][1] <= '0;
      end
    end else if (invalidate_all) begin
      lru_q <= '0;
      for (int unsigned s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
      end
    end else if (update_valid) begin
      if (u_hit) begin
        if (update_taken) begin
          if (u_ctr != 2'b11) ctr_q[u_idx][u_way] <= u_ctr + 2'd1;
        end else begin
          if (u_ctr != 2'b00) ctr_q[u_idx][u_way] <= u_ctr - 2'd1;
        end
        lru_q[u_idx] <= ~u_way;
      end else if (update_taken) begin
        valid_q[u_idx][victim] <= 1'b1;
        ctr_q[u_idx][victim]   <= 2'b10;
        lru_q[u_idx]           <= ~victim;
      end
    end
  end

  // Tag/target storage, unreset: writes while rst is high land in ways that stay invalid
  always_ff @(posedge clk) begin
    if (!invalidate_all && update_valid && update_taken) begin
      tgt_q[u_idx][wr_way] <= update_target;
      if (!u_hit) tag_q[u_idx][wr_way] <= u_tag;
    end
  end

endmodule
